// File: rtl/harp_uart_arbiter.sv
// Two-port arbiter in front of a single byte-wide UART transmitter.
// Port 0 (timestamp) has strict priority; either port may lock the UART across
// a frame, and an idle-lock timeout keeps a stalled owner from starving port 0.
module harp_uart_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned TO_WIDTH     = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_start,
  input  logic       req0_blank,
  input  logic       req0_lock,
  output logic       req0_end,
  input  logic [7:0] req1_data,
  input  logic       req1_start,
  input  logic       req1_blank,
  input  logic       req1_lock,
  output logic       req1_end,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       tx_blank,
  input  logic       tx_end,
  output logic [1:0] grant,
  output logic [1:0] overflow
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q;
  logic [1:0][7:0]     data_w;
  logic [1:0][7:0]     hold_q;
  logic [1:0]          start_w;
  logic [1:0]          blank_w;
  logic [1:0]          lock_w;
  logic [1:0]          hblank_q;
  logic [1:0]          pending_q;
  logic [1:0]          overflow_q;
  logic [1:0]          done_w;
  logic [1:0]          end_q;
  logic [1:0]          grant_q;
  logic [7:0]          tx_data_q;
  logic                tx_start_q;
  logic                tx_blank_q;
  logic                lock_valid_q;
  logic                lock_owner_q;
  logic                sel_valid;
  logic                sel_port;
  logic                to_expired;
  logic [TO_WIDTH-1:0] to_cnt_q;

  assign data_w  = {req1_data, req0_data};
  assign start_w = {req1_start, req0_start};
  assign blank_w = {req1_blank, req0_blank};
  assign lock_w  = {req1_lock, req0_lock};

  // One-hot port whose byte completes this cycle; only meaningful while waiting.
  assign done_w     = (state_q == StWait && tx_end) ? grant_q : 2'b00;
  assign to_expired = (to_cnt_q == TO_WIDTH'(LOCK_TIMEOUT));

  // Pick the next port to serve: the lock owner only, else port 0 before port 1.
  always_comb begin
    sel_valid = 1'b0;
    sel_port  = 1'b0;
    if (lock_valid_q) begin
      sel_valid = pending_q[lock_owner_q];
      sel_port  = lock_owner_q;
    end else if (pending_q[0]) begin
      sel_valid = 1'b1;
      sel_port  = 1'b0;
    end else if (pending_q[1]) begin
      sel_valid = 1'b1;
      sel_port  = 1'b1;
    end
  end

  // Per-port capture of requested bytes; a start coinciding with completion is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q     <= '0;
      hblank_q   <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (start_w[n]) begin
          if (pending_q[n] && !done_w[n]) begin
            overflow_q[n] <= 1'b1;
          end else begin
            hold_q[n]    <= data_w[n];
            hblank_q[n]  <= blank_w[n];
            pending_q[n] <= 1'b1;
          end
        end else if (done_w[n]) begin
          pending_q[n] <= 1'b0;
        end
      end
    end
  end

  // Transmit FSM with registered UART/grant outputs, lock ownership and idle-lock timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      tx_data_q    <= '0;
      tx_blank_q   <= 1'b0;
      tx_start_q   <= 1'b0;
      end_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      tx_start_q <= 1'b0;
      end_q      <= done_w;
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            state_q      <= StIssue;
            grant_q      <= sel_port ? 2'b10 : 2'b01;
            tx_data_q    <= hold_q[sel_port];
            tx_blank_q   <= hblank_q[sel_port];
            tx_start_q   <= 1'b1;
            lock_valid_q <= lock_w[sel_port];
            lock_owner_q <= sel_port;
            to_cnt_q     <= '0;
          end else if (lock_valid_q) begin
            if (!lock_w[lock_owner_q] || to_expired) begin
              lock_valid_q <= 1'b0;
              to_cnt_q     <= '0;
            end else begin
              // Owner holds the lock with nothing queued.
              to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (tx_end) begin
            grant_q <= '0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req0_end = end_q[0];
  assign req1_end = end_q[1];
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign tx_blank = tx_blank_q;
  assign grant    = grant_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_harp_uart_arbiter.sv
// Bench for harp_uart_arbiter: a cycle model of the arbitration rules checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_harp_uart_arbiter;

  localparam int LT       = 16;
  localparam int UART_LAT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req0_data, req1_data, tx_data;
  logic       req0_start, req0_blank, req0_lock, req0_end;
  logic       req1_start, req1_blank, req1_lock, req1_end;
  logic       tx_start, tx_blank, tx_end;
  logic [1:0] grant, overflow;

  harp_uart_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_data  (req0_data),
    .req0_start (req0_start),
    .req0_blank (req0_blank),
    .req0_lock  (req0_lock),
    .req0_end   (req0_end),
    .req1_data  (req1_data),
    .req1_start (req1_start),
    .req1_blank (req1_blank),
    .req1_lock  (req1_lock),
    .req1_end   (req1_end),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_blank   (tx_blank),
    .tx_end     (tx_end),
    .grant      (grant),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit uart_auto = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_pend[2] = '{0, 0};
  logic [7:0] m_hold[2] = '{8'h0, 8'h0};
  bit         m_hb[2]   = '{0, 0};
  bit [1:0]   m_ovf     = '0;
  bit [1:0]   m_end     = '0;
  int         fl_port   = -1;   // port whose byte is in flight, -1 when idle
  int         fl_age    = 0;    // 0 on the start-pulse cycle
  logic [7:0] m_txd     = '0;
  bit         m_txb     = 0;
  int         m_owner   = -1;   // lock owner, -1 when unlocked
  int         m_idle    = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = '{0, 0}; m_hold = '{8'h0, 8'h0}; m_hb = '{0, 0};
      m_ovf = '0; m_end = '0; fl_port = -1; fl_age = 0;
      m_txd = '0; m_txb = 0; m_owner = -1; m_idle = 0;
    end else begin : upd
      bit         st[2];
      bit         lk[2];
      bit         bl[2];
      logic [7:0] dt[2];
      int         done;
      int         choose;
      st = '{req0_start, req1_start};
      lk = '{req0_lock, req1_lock};
      bl = '{req0_blank, req1_blank};
      dt = '{req0_data, req1_data};
      done = (fl_port >= 0 && fl_age >= 1 && tx_end) ? fl_port : -1;
      choose = -1;
      if (fl_port < 0) begin
        if (m_owner >= 0) choose = m_pend[m_owner] ? m_owner : -1;
        else if (m_pend[0]) choose = 0;
        else if (m_pend[1]) choose = 1;
      end
      if (fl_port < 0) begin
        if (choose >= 0) begin
          fl_port = choose; fl_age = 0;
          m_txd = m_hold[choose]; m_txb = m_hb[choose];
          m_owner = lk[choose] ? choose : -1;
          m_idle = 0;
        end else if (m_owner >= 0) begin
          if (!lk[m_owner] || m_idle >= LT) begin
            m_owner = -1; m_idle = 0;
          end else begin
            m_idle++;
          end
        end
      end else if (fl_age == 0) begin
        fl_age = 1;
      end else if (done >= 0) begin
        fl_port = -1;
      end
      m_end = (done == 0) ? 2'b01 : (done == 1) ? 2'b10 : 2'b00;
      for (int n = 0; n < 2; n++) begin
        if (st[n]) begin
          if (m_pend[n] && done != n) m_ovf[n] = 1'b1;
          else begin m_pend[n] = 1'b1; m_hold[n] = dt[n]; m_hb[n] = bl[n]; end
        end else if (done == n) begin
          m_pend[n] = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", grant, (fl_port < 0) ? 2'b00 : (fl_port == 0 ? 2'b01 : 2'b10));
      check("tx_start", tx_start, (fl_port >= 0 && fl_age == 0) ? 1 : 0);
      check("tx_data", tx_data, m_txd);
      check("tx_blank", tx_blank, m_txb);
      check("req0_end", req0_end, m_end[0]);
      check("req1_end", req1_end, m_end[1]);
      check("overflow", overflow, m_ovf);
    end
  end

  // Transmit log and end-pulse counters.
  logic [9:0] sent_q[$];
  int n_end0 = 0;
  int n_end1 = 0;
  always @(negedge clk) begin
    if (tx_start) sent_q.push_back({grant, tx_data});
    if (req0_end) n_end0++;
    if (req1_end) n_end1++;
  end

  // UART stand-in: tx_end UART_LAT cycles after each start pulse.
  initial begin : uart
    int cnt;
    cnt = 0;
    tx_end = 1'b0;
    forever begin
      @(negedge clk);
      tx_end = 1'b0;
      if (reset || !uart_auto) cnt = 0;
      else if (tx_start) cnt = UART_LAT;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_end = 1'b1;
      end
    end
  end

  task automatic push(input int p, input logic [7:0] d, input logic b);
    if (p == 0) begin req0_data = d; req0_blank = b; req0_start = 1'b1; end
    else        begin req1_data = d; req1_blank = b; req1_start = 1'b1; end
    @(negedge clk);
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic wait_end(input int p, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((p == 0 && req0_end) || (p == 1 && req1_end)) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  // Drive a start now and return the number of negedges until tx_start, -1 if none.
  task automatic start_latency(input int p, input logic [7:0] d, input int budget,
                               output int lat);
    lat = -1;
    if (p == 0) begin req0_data = d; req0_start = 1'b1; end
    else        begin req1_data = d; req1_start = 1'b1; end
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      req0_start = 1'b0;
      req1_start = 1'b0;
      if (tx_start) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int e0;
    int e1;
    reset = 1'b1;
    req0_data = '0; req0_start = 0; req0_blank = 0; req0_lock = 0;
    req1_data = '0; req1_start = 0; req1_blank = 0; req1_lock = 0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_grant", grant, 2'b00);
    check("rst_tx_start", tx_start, 0);
    check("rst_overflow", overflow, 2'b00);
    reset = 1'b0;
    @(negedge clk);

    // 1: single byte on port 1
    sent_q.delete();
    start_latency(1, 8'h5A, 10, lat);
    check("t1_latency", lat, 2);
    check("t1_data", tx_data, 8'h5A);
    check("t1_grant", grant, 2'b10);
    wait_end(1, 20, "t1_end_seen");
    check("t1_grant_cleared", grant, 2'b00);
    repeat (3) @(negedge clk);

    // 2: simultaneous starts, port 0 first
    sent_q.delete();
    e0 = n_end0; e1 = n_end1;
    req0_data = 8'hAA; req1_data = 8'h11;
    req0_start = 1'b1; req1_start = 1'b1;
    @(negedge clk);
    req0_start = 1'b0; req1_start = 1'b0;
    repeat (25) @(negedge clk);
    check("t2_count", sent_q.size(), 2);
    if (sent_q.size() >= 2) begin
      check("t2_first", sent_q[0], {2'b01, 8'hAA});
      check("t2_second", sent_q[1], {2'b10, 8'h11});
    end
    check("t2_end0", n_end0 - e0, 1);
    check("t2_end1", n_end1 - e1, 1);

    // 3: locked 3-byte frame on port 1 blocks port 0 until the lock drops
    sent_q.delete();
    req1_lock = 1'b1;
    push(1, 8'h01, 1'b1);
    wait_end(1, 20, "t3_b1_end");
    push(0, 8'hAF, 1'b0);
    push(1, 8'h02, 1'b0);
    wait_end(1, 20, "t3_b2_end");
    push(1, 8'h03, 1'b0);
    wait_end(1, 20, "t3_b3_end");
    repeat (3) @(negedge clk);
    check("t3_blocked_grant", grant, 2'b00);
    req1_lock = 1'b0;
    wait_end(0, 20, "t3_af_end");
    check("t3_count", sent_q.size(), 4);
    if (sent_q.size() >= 4) begin
      check("t3_b1", sent_q[0], {2'b10, 8'h01});
      check("t3_b3", sent_q[2], {2'b10, 8'h03});
      check("t3_af", sent_q[3], {2'b01, 8'hAF});
    end
    check("t3_overflow", overflow, 2'b00);
    repeat (2) @(negedge clk);

    // 4: lock timeout releases a stalled owner
    req1_lock = 1'b1;
    push(1, 8'h44, 1'b0);
    wait_end(1, 20, "t4_b1_end");
    start_latency(0, 8'h55, 40, lat);
    check("t4_timeout_latency", lat, 18);
    check("t4_grant", grant, 2'b01);
    check("t4_data", tx_data, 8'h55);
    req1_lock = 1'b0;
    wait_end(0, 20, "t4_end");
    repeat (2) @(negedge clk);

    // 5: overflow on back-to-back port 0 starts
    sent_q.delete();
    req0_data = 8'h66; req0_start = 1'b1;
    @(negedge clk);
    req0_data = 8'h77;
    @(negedge clk);
    req0_start = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_overflow", overflow, 2'b01);
    check("t5_count", sent_q.size(), 1);
    if (sent_q.size() >= 1) check("t5_byte", sent_q[0], {2'b01, 8'h66});

    // 6: reset while waiting for tx_end
    uart_auto = 1'b0;
    push(0, 8'h99, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_in_wait_grant", grant, 2'b01);
    e0 = n_end0;
    #2 reset = 1'b1;
    #1;
    check("t6_rst_grant", grant, 2'b00);
    check("t6_rst_tx_data", tx_data, 8'h00);
    check("t6_rst_overflow", overflow, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_end", n_end0 - e0, 0);
    uart_auto = 1'b1;
    sent_q.delete();
    push(0, 8'h33, 1'b1);
    wait_end(0, 20, "t6_end");
    check("t6_count", sent_q.size(), 1);
    if (sent_q.size() >= 1) check("t6_byte", sent_q[0], {2'b01, 8'h33});
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/harp_uart_arbiter.md
Name: harp_uart_arbiter

Overview:
- Shares one byte-wide UART transmitter between two requesters.
- Port 0 is the time-critical harp timestamp counter; port 1 is a lower-priority status/debug byte source.
- Each requester drives start pulses and data, and receives per-byte end pulses. The UART sees a single start/data/blank stream and returns tx_end.
- Port 1 can lock the UART across a multi-byte frame. A lock timeout prevents a hung requester from blocking the timestamp path indefinitely.

Parameters:
LOCK_TIMEOUT, 4096, idle cycles an owner may hold a lock with no pending byte before the lock is forcibly released
TO_WIDTH, $clog2(LOCK_TIMEOUT+1), width of the lock-timeout counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req0_data  input  8  port 0 byte, sampled on req0_start
req0_start  input  1  port 0 one-cycle byte request
req0_blank  input  1  port 0 blank flag, sampled with the byte
req0_lock  input  1  port 0 frame lock (high across a frame)
req0_end  output  1  one-cycle pulse: port 0 byte fully sent
req1_data  input  8  port 1 byte
req1_start  input  1  port 1 one-cycle byte request
req1_blank  input  1  port 1 blank flag
req1_lock  input  1  port 1 frame lock
req1_end  output  1  one-cycle pulse: port 1 byte fully sent
tx_data  output  8  byte to UART, stable from tx_start until tx_end
tx_start  output  1  one-cycle start pulse to UART
tx_blank  output  1  blank flag for the current byte
tx_end  input  1  UART byte-complete pulse
grant  output  2  one-hot current owner; 00 when none
overflow  output  2  sticky per-port flag: start while that port's byte still pending

Behaviour:
- Reset: all outputs 0, pending[1:0]=0, lock owner none, timeout counter 0, state S_IDLE. Reset mid-byte aborts silently; no end pulse is issued.
- Capture:
  - reqN_start with pending[N]=0 latches data and blank into holdN and sets pending[N] at that edge.
  - reqN_start with pending[N]=1 drops the byte and sets overflow[N]. overflow[N] clears only on reset.
  - If a start arrives on the same edge that pending[N] clears, the start wins and the new byte is accepted.
- Eligibility:
  - If lock_owner is valid, only that port is eligible.
  - Otherwise a pending port is eligible; port 0 has strict priority over port 1.
- States:
  - S_IDLE: when a port is eligible and pending, set grant, tx_data=holdN, tx_blank=blankN, and go to S_ISSUE.
  - S_ISSUE: tx_start=1 for exactly one cycle; go to S_WAIT.
  - S_WAIT: hold tx_data and tx_blank. On tx_end: clear pending[owner], pulse reqN_end for one cycle on the next cycle (registered), clear grant, go to S_IDLE.
- Latency: with the UART idle and the port eligible, tx_start is asserted 2 cycles after the reqN_start cycle. Next-byte turnaround from tx_end to the next tx_start is 2 cycles.
- Lock:
  - At the S_IDLE→S_ISSUE transition, if reqN_lock=1 then lock_owner=N.
  - The lock releases when the owner's lock input is low in S_IDLE.
  - The lock is also released when the timeout counter reaches LOCK_TIMEOUT. The counter increments each S_IDLE cycle while locked and the owner has no pending byte, resets on any grant, and saturates.
  - A forced release does not set overflow. The owner may re-acquire the lock on its next grant.
- Blocked requests: a request from the non-owner while locked stays pending with no error.
- tx_end outside S_WAIT is ignored.
- Simultaneous pending on both ports with no lock: port 0 is granted first, then port 1.

Test Plan:
1. Single byte: req1_start with data 0x5A, lock=0 → tx_start 2 cycles later with tx_data=0x5A; return tx_end → req1_end pulses 1 cycle later; grant returns to 00.
2. Priority: req0 (0xAA) and req1 (0x11) start in the same cycle → 0xAA sent first, then 0x11; end pulses go to the correct ports.
3. Lock: req1 sends 3 bytes with lock=1 while req0 starts 0xAF after byte 1 → 0xAF is held until req1_lock falls, then sent; overflow=00.
4. Timeout: LOCK_TIMEOUT=16, req1 locks, sends 1 byte, then holds lock with no start; req0 pending → req0 granted after 16 idle cycles.
5. Overflow: a second req0_start while req0's byte is still pending → overflow[0]=1 and the second byte is never transmitted; the first byte is sent intact.
6. Reset mid-byte: assert reset in S_WAIT → all outputs 0 immediately; no reqN_end; after release, a new 0x33 request sends normally.
